// File: rtl/simon_iter_ctrl_if.sv
// rtl/simon_iter_ctrl_if.sv - block in/out handshake bundle for the Simon engine
interface simon_iter_ctrl_if #(
    parameter int N = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] in_block;
    logic           in_decrypt;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out_block;

    // Host side: offers blocks, consumes results
    modport master (
        output in_valid, in_block, in_decrypt, out_ready,
        input  in_ready, out_valid, out_block
    );

    // Engine side
    modport slave (
        input  in_valid, in_block, in_decrypt, out_ready,
        output in_ready, out_valid, out_block
    );
endinterface

// File: rtl/simon_iter_ctrl.sv
// rtl/simon_iter_ctrl.sv - iterative Simon round engine with external round-key store
module simon_iter_ctrl #(
    parameter int N  = 16,
    parameter int T  = 32,
    parameter int AW = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    simon_iter_ctrl_if.slave     blk,
    output logic                 rk_en,
    output logic [AW-1:0]        rk_addr,
    input  logic [N-1:0]         rk_data,
    output logic                 busy
);
    localparam int CW = $clog2(T) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(T - 1);
    localparam logic [CW-1:0] CNT_PEN   = CW'(T - 2);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(T - 1);

    logic [1:0]     state;
    logic [CW-1:0]  cnt;
    logic           mode;
    logic [2*N-1:0] s;
    logic [2*N-1:0] s_next;
    logic [2*N-1:0] out_q;
    logic [AW-1:0]  addr_q;
    logic [AW-1:0]  addr_step;

    function automatic logic [N-1:0] rol(input logic [N-1:0] x, input int k);
        return (x << k) | (x >> (N - k));
    endfunction

    function automatic logic [N-1:0] f(input logic [N-1:0] x);
        return (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
    endfunction

    function automatic logic [2*N-1:0] swap(input logic [2*N-1:0] v);
        return {v[N-1:0], v[2*N-1:N]};
    endfunction

    // One Feistel round on the current state using the key fetched last cycle
    always_comb begin
        s_next = {f(s[2*N-1:N]) ^ s[N-1:0] ^ rk_data, s[2*N-1:N]};
    end

    // Key index walks up for encryption, down for decryption
    always_comb begin
        addr_step = mode ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
    end

    // Control FSM, round state, key address and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            mode   <= 1'b0;
            s      <= '0;
            out_q  <= '0;
            addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (blk.in_valid) begin
                        mode   <= blk.in_decrypt;
                        s      <= blk.in_decrypt ? swap(blk.in_block) : blk.in_block;
                        addr_q <= blk.in_decrypt ? ADDR_LAST : '0;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    cnt    <= '0;
                    addr_q <= addr_step;
                    state  <= ROUND;
                end
                ROUND: begin
                    s   <= s_next;
                    cnt <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        out_q <= mode ? swap(s_next) : s_next;
                        state <= DONE;
                    end else if (cnt != CNT_PEN) begin
                        // Address already points at the final key once c reaches T-2
                        addr_q <= addr_step;
                    end
                end
                DONE: begin
                    if (blk.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign blk.in_ready  = (state == IDLE);
    assign blk.out_valid = (state == DONE);
    assign blk.out_block = out_q;
    assign rk_en         = (state == FETCH) || ((state == ROUND) && (cnt != CNT_LAST));
    assign rk_addr       = addr_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_simon_iter_ctrl.sv
// tb/tb_simon_iter_ctrl.sv - scoreboard bench for simon_iter_ctrl with Simon32/64 vectors
module tb_simon_iter_ctrl;
    localparam int N  = 16;
    localparam int T  = 32;
    localparam int AW = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    simon_iter_ctrl_if #(.N(N)) blk ();
    logic          rk_en;
    logic [AW-1:0] rk_addr;
    logic [N-1:0]  rk_data = '0;
    logic          busy;

    simon_iter_ctrl #(.N(N), .T(T), .AW(AW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .blk    (blk),
        .rk_en  (rk_en),
        .rk_addr(rk_addr),
        .rk_data(rk_data),
        .busy   (busy)
    );

    logic [N-1:0] rk_mem [0:(1<<AW)-1];

    // Synchronous key store, one cycle read latency
    always @(posedge clk) if (rk_en) rk_data <= rk_mem[rk_addr];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*N-1:0] blk;
        int             acc;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input logic [2*N-1:0] b, input int acc);
        exp_t e;
        e.blk = b;
        e.acc = acc;
        sb.push_back(e);
    endtask

    function automatic logic [N-1:0] ror(input logic [N-1:0] x, input int k);
        return (x >> k) | (x << (N - k));
    endfunction

    // Simon32/64 key schedule for key 1918 1110 0908 0100
    task automatic keygen();
        logic [61:0]  z0;
        logic [N-1:0] tmp;
        z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
        rk_mem[0] = 16'h0100;
        rk_mem[1] = 16'h0908;
        rk_mem[2] = 16'h1110;
        rk_mem[3] = 16'h1918;
        for (int i = 4; i < T; i++) begin
            tmp = ror(rk_mem[i-1], 3) ^ rk_mem[i-3];
            tmp = tmp ^ ror(tmp, 1);
            rk_mem[i] = ~rk_mem[i-4] ^ tmp ^ {15'd0, z0[61-((i-4)%62)]} ^ 16'h0003;
        end
    endtask

    // Monitor: latency on out_valid rise, block value on each output handshake
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (blk.out_valid && !prev_v) begin
                if (sb.size() == 0) check("out_without_request", sb.size(), 1);
                else check("latency", cyc - sb[0].acc, T + 1);
            end
            if (blk.out_valid && blk.out_ready && sb.size() > 0) begin
                check("out_block", blk.out_block, sb[0].blk);
                void'(sb.pop_front());
            end
        end
        prev_v = blk.out_valid;
    end

    task automatic send(input logic [2*N-1:0] b, input logic dec, output int acc);
        int n;
        acc = -1;
        blk.in_block   = b;
        blk.in_decrypt = dec;
        blk.in_valid   = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (blk.in_ready) break;
        end
        if (n == 200) begin
            check("accept_timeout", n, 0);
            blk.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            blk.in_valid = 1'b0;
        end
    endtask

    task automatic check_rk(input logic dec);
        int ea;
        for (int i = 0; i <= T; i++) begin
            @(negedge clk);
            ea = (i < T - 1) ? i : T - 1;
            if (dec) ea = T - 1 - ea;
            check($sformatf("rk_en[%0d]", i), rk_en, (i < T));
            check($sformatf("rk_addr[%0d]", i), rk_addr, ea);
        end
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!busy && !blk.out_valid) break;
        end
        if (n == 200) check("idle_timeout", n, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  blk.in_ready, 1);
        check({tag, "_out_valid"}, blk.out_valid, 0);
        check({tag, "_out_block"}, blk.out_block, 0);
        check({tag, "_rk_en"},     rk_en, 0);
        check({tag, "_rk_addr"},   rk_addr, 0);
        check({tag, "_busy"},      busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, a1, a2, n;
        blk.in_valid   = 1'b0;
        blk.in_block   = '0;
        blk.in_decrypt = 1'b0;
        blk.out_ready  = 1'b1;
        keygen();
        check("k4", rk_mem[4], 16'h71c3);

        #3;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Encrypt known vector, walk the key address sequence
        send(32'h6565_6877, 1'b0, acc);
        expect_out(32'hc69b_e9bb, acc);
        check_rk(1'b0);
        wait_idle();

        // Decrypt back
        send(32'hc69b_e9bb, 1'b1, acc);
        expect_out(32'h6565_6877, acc);
        check_rk(1'b1);
        wait_idle();

        // Backpressure in DONE with ignored in_valid pulses
        blk.out_ready = 1'b0;
        send(32'h6565_6877, 1'b0, acc);
        expect_out(32'hc69b_e9bb, acc);
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (blk.out_valid) break;
        end
        check("bp_reach_done", blk.out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            blk.in_valid = i[0];
            blk.in_block = 32'h1234_5678;
            @(negedge clk);
            check("bp_out_valid", blk.out_valid, 1);
            check("bp_out_block", blk.out_block, 32'hc69b_e9bb);
            check("bp_in_ready", blk.in_ready, 0);
        end
        @(posedge clk);
        #1;
        blk.in_valid  = 1'b0;
        blk.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_out_valid", blk.out_valid, 0);
        check("bp_release_in_ready", blk.in_ready, 1);
        check("bp_release_busy", busy, 0);
        @(posedge clk);
        #1;

        // Asynchronous reset while the round counter sits at 12
        send(32'h6565_6877, 1'b0, acc);
        repeat (13) @(posedge clk);
        #3;
        check("busy_before_reset", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_out_valid", blk.out_valid, 0);
        @(posedge clk);
        #1;
        send(32'h6565_6877, 1'b0, acc);
        expect_out(32'hc69b_e9bb, acc);
        wait_idle();

        // Back-to-back: second block held valid throughout the first
        send(32'h6565_6877, 1'b0, a1);
        expect_out(32'hc69b_e9bb, a1);
        send(32'hc69b_e9bb, 1'b1, a2);
        expect_out(32'h6565_6877, a2);
        check("b2b_gap", a2 - a1, T + 3);
        wait_idle();

        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/simon_iter_ctrl.md
Name: simon_iter_ctrl

Overview:
- Iterative Simon block-cipher engine: accepts one 2N-bit block per transaction and applies T Feistel rounds, one per clock.
- Fetches round keys from an external round-key store that has 1-cycle synchronous read latency.
- Returns the result over a valid/ready handshake.
- Supports encryption and decryption. Sits between the host-side block interface and the key-schedule RAM filled by the key expander.

Parameters:
- N, 16, word size in bits; must be >= 9.
- T, 32, number of rounds; must be >= 2.
- AW, 5, round-key address width; must satisfy 2^AW >= T.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input block offered.
- in_ready  output  1  engine can accept a block.
- in_block  input  2N  input block; upper N bits = x1, lower N bits = x0.
- in_decrypt  input  1  0 = encrypt, 1 = decrypt; sampled with in_block.
- rk_en  output  1  round-key read strobe.
- rk_addr  output  AW  round-key index to read.
- rk_data  input  N  round key, valid the cycle after rk_en/rk_addr.
- out_valid  output  1  result block available.
- out_ready  input  1  consumer accepts the result.
- out_block  output  2N  result block.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async assert of rst_n low):
  - State goes to IDLE. The state, counter and mode registers clear to 0.
  - in_ready=1, out_valid=0, out_block=0, rk_en=0, rk_addr=0, busy=0.
  - Reset mid-operation aborts the operation; no output is produced.
- Round function, on state S = {x1, x0}:
  - f(x) = (rol1(x) & rol8(x)) ^ rol2(x), where rolk is a left rotate by k within N bits.
  - S' = {f(x1) ^ x0 ^ k, x1}.
- FSM states: IDLE, FETCH, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready:
    - Latch mode = in_decrypt.
    - Encrypt: S = in_block.
    - Decrypt: S = {in_block[N-1:0], in_block[2N-1:N]} (halves swapped).
    - Go to FETCH.
- FETCH (one cycle):
  - rk_en=1.
  - rk_addr = 0 for encrypt, T-1 for decrypt.
  - Clear round counter c=0. Go to ROUND.
- ROUND (T cycles, c = 0..T-1):
  - Each edge applies one round using rk_data as k, then increments c.
  - When c < T-1: rk_en=1 and rk_addr = next key index (c+1 encrypt, T-2-c decrypt). Key fetch is always one round ahead.
  - When c = T-1: rk_en=0, rk_addr holds its last value.
  - After the round with c=T-1, go to DONE.
- DONE:
  - out_valid=1.
  - Encrypt: out_block = S. Decrypt: out_block = S with halves swapped.
  - out_block is registered and stays stable while out_valid=1 and out_ready=0.
  - On out_ready: out_valid drops on the same edge and the FSM returns to IDLE.
- Latency: out_valid rises exactly T+1 clock edges after the input handshake edge. Throughput is one block per T+3 cycles minimum.
- in_ready=0 in FETCH, ROUND and DONE. in_valid is ignored outside IDLE. in_block and in_decrypt need only be valid at the handshake.
- rk_data is sampled only in ROUND; its value in other states has no effect.
- out_ready while out_valid=0 has no effect.
- No back-to-back overlap: a new block cannot be accepted in the same cycle as a DONE handshake. IDLE is always visited.
- Counter width is ceil(log2 T)+1. The counter never wraps: the FSM leaves ROUND at c=T-1.

Test Plan:
- Reset check: reset asserted asynchronously between edges -> all outputs immediately take the reset values listed above.
- Encrypt, N=16, T=32, rk memory preloaded with the Simon32/64 schedule for key 1918_1110_0908_0100 (k0=0100), in_block=6565_6877 -> out_block=c69b_e9bb. out_valid rises 33 edges after acceptance. rk_addr sequence is 0,1,...,31.
- Decrypt, same keys, in_block=c69b_e9bb, in_decrypt=1 -> out_block=6565_6877. rk_addr sequence is 31,30,...,0. rk_en low during the final round.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_block stable, in_ready=0, and in_valid pulses are ignored. Then raise out_ready -> out_valid drops, in_ready=1 on the next cycle.
- Reset mid-round: assert rst_n low at c=12 -> busy=0 and out_valid=0 with no result emitted. A fresh encrypt of 6565_6877 after release -> c69b_e9bb.
- Back-to-back: two blocks, the second offered continuously with in_valid=1 -> the second is accepted only in the cycle after returning to IDLE, and both results match the reference model.
